pwm8_axil_slave: RTL and testbench
==================================

# pwm8_axil_slave

AXI4-Lite responder for the 8-channel PWM peripheral. It accepts single-beat register writes and reads from the PS or the AXI4-Lite master BFM, holds the control, period and duty registers, and drives eight PWM outputs from one shared period counter. Period and duty updates take effect only at period boundaries, so no output ever produces a runt pulse.

## Interface

- C_S_AXI_DATA_WIDTH, 32, AXI data width; this is the only supported value.
- C_S_AXI_ADDR_WIDTH, 6, byte address width; bits [5:2] select the register.
- C_PWM_WIDTH, 16, width of the counter, period and duty fields.
- s00_axi_aclk  in  1  single clock for all logic.
- s00_axi_aresetn  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to s00_axi_aclk.
- s00_axi_awaddr/awprot/awvalid/awready  in/in/in/out  6/3/1/1  write address channel; awprot is ignored.
- s00_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s00_axi_araddr/arprot/arvalid/arready  in/in/in/out  6/3/1/1  read address channel; arprot is ignored.
- s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- pwm_out  out  8  PWM outputs; bit i is channel i.

## Operation

Register map (word-aligned):
- 0x00 CTRL: R/W, 32 bits; bits [7:0] are the per-channel enables.
- 0x04 PERIOD: R/W, 32 bits; bits [15:0] are the period in clocks.
- 0x08 + 4·i, i = 0..7, DUTY_i: R/W, 32 bits; bits [15:0] are the high time in clocks.
- 0x28 STATUS: RO; [15:0] is the live counter value; [23:16] is pwm_out.
- 0x2C..0x3C: unmapped.

Register access:
- All R/W registers store the full 32 bits, so readback equals the last write.
- wstrb[k] gates byte k of the write.
- Writes to STATUS and to unmapped addresses are dropped.
- Reads of unmapped addresses return 0.
- bresp and rresp are always OKAY (2'b00).

Write path:
- AW and W are accepted together. awready and wready pulse high for one cycle when awvalid && wvalid && !bvalid && !awready.
- The register is written at the end of that cycle.
- bvalid rises on the next cycle and holds until bready is sampled high.
- Address and data arriving on different cycles wait until both are present.

Read path:
- arready pulses for one cycle when arvalid && !rvalid && !arready.
- rdata is registered on that edge; rvalid rises on the next cycle and holds, with rdata stable, until rready.

Read and write in the same cycle to the same register: the read returns the value before the write.

PWM generation:
- Shadow registers per_s and duty_s[i] are loaded from PERIOD and DUTY_i when the counter wraps, and also when per_s == 0.
- If per_s == 0, the counter is held at 0 and all pwm_out are 0.
- Otherwise the counter counts 0..per_s−1, then wraps to 0. A shadow load happens on the wrap edge.
- pwm_out[i] = CTRL[i] && (cnt < duty_s[i]), registered.
- duty_s[i] ≥ per_s gives a constant high output; duty_s[i] == 0 gives a constant low output.
- CTRL enables act immediately and are not shadowed.

## Timing

- Reset values:
  - awready, wready, bvalid, arready, rvalid = 0.
  - bresp, rresp, rdata = 0.
  - All registers = 0; shadows = 0; counter = 0; pwm_out = 0.
- Write latency: accept in cycle N, register updated at the N edge, bvalid in cycle N+1. Minimum of 3 cycles per back-to-back write with bready held high.
- Read latency: arready in cycle N, rvalid in cycle N+1.
- pwm_out is registered and lags the counter compare by 1 cycle. With per_s = P, the period at pwm_out is exactly P clocks.
- A new DUTY or PERIOD value appears at pwm_out in the first cycle of the next period.
- Reset asserted mid-transaction: all valids and readies drop immediately and any pending response is discarded. The master must restart.
- Backpressure: while bvalid or rvalid is pending, no new transaction is accepted on that channel.

## Test plan

- Register write/readback:
  - Stimulus: write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x00, 0x04, 0x08, 0x0C.
  - Response: each read returns the written value; every bresp and rresp = 0.
- Byte strobes:
  - Stimulus: write DUTY0 = 0xFFFFFFFF, then write 0x12345678 with wstrb = 4'b0101.
  - Response: read returns 0xFF34FF78.
- PWM waveform:
  - Stimulus: PERIOD = 10, DUTY3 = 4, CTRL = 0x08.
  - Response: pwm_out[3] is high 4 clocks, low 6 clocks, repeating; the other bits stay 0.
- Glitch-free update:
  - Stimulus: with PERIOD = 10 running, write DUTY3 = 7 mid-period.
  - Response: the current period keeps 4 high clocks; the next period has 7.
- Boundaries:
  - DUTY = 0 gives a constant low output.
  - DUTY = 12 with PERIOD = 10 gives a constant high output.
  - PERIOD = 0 gives all outputs low and STATUS[15:0] = 0.
  - A read of 0x30 returns 0 with OKAY.
- Handshake and reset:
  - AW held 3 cycles before W: no accept until W arrives.
  - bready held low 5 cycles: bvalid stays high and no second write is accepted.
  - aresetn pulsed during a pending rvalid: rvalid = 0 immediately and all registers read back 0.

Source files
------------

// File: rtl/pwm8_axil_slave_if.sv
// rtl/pwm8_axil_slave_if.sv - AXI4-Lite bus bundle between a master and the PWM register slave
interface pwm8_axil_slave_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/pwm8_axil_slave.sv
// rtl/pwm8_axil_slave.sv - AXI4-Lite register slave driving eight PWM channels
// from one shared counter, with period/duty shadowed at period boundaries.
module pwm8_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_PWM_WIDTH        = 16
) (
  input  logic             s00_axi_aclk,
  input  logic             s00_axi_aresetn,
  pwm8_axil_slave_if.slave s00_axi,
  output logic [7:0]       pwm_out
);
  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int AW   = C_S_AXI_ADDR_WIDTH;
  localparam int PW   = C_PWM_WIDTH;
  localparam int NCH  = 8;
  localparam int NREG = 10;

  localparam logic [3:0] IDX_CTRL   = 4'd0;
  localparam logic [3:0] IDX_PERIOD = 4'd1;
  localparam logic [3:0] IDX_STATUS = 4'd10;

  logic           awready_q, awready_d;
  logic           bvalid_q, bvalid_d;
  logic           arready_q, arready_d;
  logic           rvalid_q, rvalid_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [DW-1:0]  regs_q [NREG];
  logic [DW-1:0]  regs_d [NREG];
  logic [PW-1:0]  per_s_q, per_s_d;
  logic [PW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  duty_s_q [NCH];
  logic [PW-1:0]  duty_s_d [NCH];
  logic [NCH-1:0] pwm_q, pwm_d;

  logic [3:0]     wr_idx;
  logic [3:0]     rd_idx;
  logic           wr_en;
  logic [DW-1:0]  wr_word;
  logic [DW-1:0]  rd_mux;
  logic           per_zero;
  logic           wrap;
  logic           shadow_load;
  logic           unused_ok;

  assign wr_idx = s00_axi.awaddr[AW-1:2];
  assign rd_idx = s00_axi.araddr[AW-1:2];
  assign wr_en  = awready_q && s00_axi.awvalid && s00_axi.wvalid;

  assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot,
                       s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

  // AW and W are taken together; the accept pulse itself blocks a second accept.
  always_comb begin
    awready_d = s00_axi.awvalid && s00_axi.wvalid && !bvalid_q && !awready_q;
    bvalid_d  = bvalid_q;
    if (wr_en) begin
      bvalid_d = 1'b1;
    end else if (bvalid_q && s00_axi.bready) begin
      bvalid_d = 1'b0;
    end

    arready_d = s00_axi.arvalid && !rvalid_q && !arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    if (arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rvalid_q && s00_axi.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (rd_idx < IDX_STATUS) begin
      rd_mux = regs_q[rd_idx];
    end else if (rd_idx == IDX_STATUS) begin
      rd_mux = {{(DW-NCH-PW){1'b0}}, pwm_q, cnt_q};
    end
  end

  always_comb begin
    wr_word = '0;
    if (wr_idx < IDX_STATUS) begin
      wr_word = regs_q[wr_idx];
    end
    for (int b = 0; b < DW/8; b++) begin
      if (s00_axi.wstrb[b]) begin
        wr_word[8*b +: 8] = s00_axi.wdata[8*b +: 8];
      end
    end
    for (int r = 0; r < NREG; r++) begin
      regs_d[r] = (wr_en && wr_idx == 4'(r)) ? wr_word : regs_q[r];
    end
  end

  // A zero shadow period keeps reloading so a fresh PERIOD starts without waiting for a wrap.
  assign per_zero    = (per_s_q == '0);
  assign wrap        = !per_zero && (cnt_q == per_s_q - PW'(1));
  assign shadow_load = per_zero || wrap;

  always_comb begin
    per_s_d = shadow_load ? regs_q[IDX_PERIOD][PW-1:0] : per_s_q;
    cnt_d   = shadow_load ? '0 : cnt_q + PW'(1);
    for (int i = 0; i < NCH; i++) begin
      duty_s_d[i] = shadow_load ? regs_q[i + 2][PW-1:0] : duty_s_q[i];
      pwm_d[i]    = !per_zero && regs_q[IDX_CTRL][i] && (cnt_q < duty_s_q[i]);
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      per_s_q   <= '0;
      cnt_q     <= '0;
      pwm_q     <= '0;
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      for (int i = 0; i < NCH; i++) begin
        duty_s_q[i] <= '0;
      end
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      per_s_q   <= per_s_d;
      cnt_q     <= cnt_d;
      pwm_q     <= pwm_d;
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
      end
      for (int i = 0; i < NCH; i++) begin
        duty_s_q[i] <= duty_s_d[i];
      end
    end
  end

  assign s00_axi.awready = awready_q;
  assign s00_axi.wready  = awready_q;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = 2'b00;
  assign s00_axi.arready = arready_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = 2'b00;
  assign pwm_out         = pwm_q;
endmodule

// File: tb/tb_pwm8_axil_slave.sv
// tb/tb_pwm8_axil_slave.sv - scoreboard bench for the AXI4-Lite PWM slave
module tb_pwm8_axil_slave;
  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } rd_exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pwm_out;

  always #5 clk = ~clk;

  pwm8_axil_slave_if bus ();

  pwm8_axil_slave dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .s00_axi        (bus),
    .pwm_out        (pwm_out)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [10];
  rd_exp_t     exp_rd [$];
  int          exp_b = 0;
  logic [7:0]  cap [$];
  bit          cap_en = 1'b0;
  rd_exp_t     mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < 10; r++) model[r] = '0;
  endfunction

  function automatic void model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a[5:2]);
    if (idx <= 9)
      for (int b = 0; b < 4; b++)
        if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] a);
    int idx;
    idx = int'(a[5:2]);
    return (idx <= 9) ? model[idx] : 32'h0;
  endfunction

  // Monitor: every completed response is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst_n && bus.rvalid && bus.rready) begin
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got rdata 0x%0h with no read outstanding", bus.rdata);
      end else begin
        mon_e = exp_rd.pop_front();
        check($sformatf("rdata@%02h", mon_e.addr), bus.rdata, mon_e.data);
        check($sformatf("rresp@%02h", mon_e.addr), 32'(bus.rresp), 32'h0);
      end
    end
    if (rst_n && bus.bvalid && bus.bready) begin
      if (exp_b == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got bvalid with no write outstanding");
      end else begin
        exp_b--;
        check("bresp", 32'(bus.bresp), 32'h0);
      end
    end
    if (cap_en) cap.push_back(pwm_out);
  end

  task automatic bus_idle();
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.bready = 1'b1; bus.rready = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus_idle();
    exp_rd.delete(); exp_b = 0; model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic start_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    exp_b++;
  endtask

  task automatic wait_accept(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.awready && n < 100);
    if (!bus.awready) begin
      checks++; errors++; exp_b--;
      $display("FAIL %s_accept: awready 0 after %0d cycles, required 1", name, n);
    end else begin
      check({name, "_wready"}, 32'(bus.wready), 32'h1);
      model_write(bus.awaddr, bus.wdata, bus.wstrb);
    end
  endtask

  task automatic end_write();
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  task automatic wait_b(input string name);
    int n = 0;
    while (exp_b != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_b != 0) begin
      checks++; errors++;
      $display("FAIL %s_bvalid: %0d responses missing, required 0", name, exp_b);
      exp_b = 0;
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    start_write(a, d, s);
    wait_accept($sformatf("wr%02h", a));
    end_write();
    wait_b($sformatf("wr%02h", a));
  endtask

  task automatic axi_read(input logic [5:0] a, input logic [31:0] e);
    int n = 0;
    rd_exp_t x;
    @(posedge clk); #1;
    x.addr = a; x.data = e;
    exp_rd.push_back(x);
    bus.araddr = a; bus.arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.arready && n < 100);
    if (!bus.arready) begin
      checks++; errors++;
      $display("FAIL rd%02h_accept: arready 0 after %0d cycles, required 1", a, n);
      exp_rd.delete();
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    n = 0;
    while (exp_rd.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_rd.size() != 0) begin
      checks++; errors++;
      $display("FAIL rd%02h_rvalid: no response after %0d cycles", a, n);
      exp_rd.delete();
    end
  endtask

  task automatic capture(input int ncyc);
    cap.delete();
    cap_en = 1'b1;
    repeat (ncyc) @(posedge clk);
    cap_en = 1'b0;
  endtask

  // Channel 3 must be high for duty clocks then low for the rest of each P-clock period.
  task automatic check_wave(input string name, input int p, input int d_first, input int d_rest, input int nper);
    int r = -1;
    logic [7:0] orv = '0;
    for (int i = 1; i < cap.size(); i++)
      if (cap[i][3] && !cap[i-1][3]) begin r = i; break; end
    if (r < 0 || r + p * nper > cap.size()) begin
      checks++; errors++;
      $display("FAIL %s_edge: no full periods after rising edge (edge at %0d, %0d samples)", name, r, cap.size());
      return;
    end
    for (int k = 0; k < nper; k++) begin
      logic [31:0] act, exp;
      int d;
      d = (k == 0) ? d_first : d_rest;
      act = '0; exp = '0;
      for (int j = 0; j < p; j++) begin
        act[j] = cap[r + k * p + j][3];
        exp[j] = (j < d);
      end
      check($sformatf("%s_period%0d", name, k), act, exp);
    end
    foreach (cap[i]) orv = orv | cap[i];
    check({name, "_other_ch"}, 32'(orv & 8'hF7), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit   prev;
    bit   found;
    int   ones;
    bus_idle();
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(bus.awready), 0);
    check("rst_wready",  32'(bus.wready), 0);
    check("rst_bvalid",  32'(bus.bvalid), 0);
    check("rst_arready", 32'(bus.arready), 0);
    check("rst_rvalid",  32'(bus.rvalid), 0);
    check("rst_bresp",   32'(bus.bresp), 0);
    check("rst_rresp",   32'(bus.rresp), 0);
    check("rst_rdata",   bus.rdata, 0);
    check("rst_pwm",     32'(pwm_out), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int r = 0; r <= 10; r++) axi_read(6'(r * 4), 32'h0);

    axi_write(6'h00, 32'h0101FFFF, 4'hF);
    axi_write(6'h04, 32'hABCD0001, 4'hF);
    axi_write(6'h08, 32'hDEAD0011, 4'hF);
    axi_write(6'h0C, 32'hBEEF0011, 4'hF);
    axi_read(6'h00, 32'h0101FFFF);
    axi_read(6'h04, 32'hABCD0001);
    axi_read(6'h08, 32'hDEAD0011);
    axi_read(6'h0C, 32'hBEEF0011);

    axi_write(6'h08, 32'hFFFFFFFF, 4'hF);
    axi_write(6'h08, 32'h12345678, 4'b0101);
    axi_read(6'h08, 32'hFF34FF78);

    for (int k = 0; k < 60; k++) begin
      logic [3:0] idx;
      idx = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        axi_write({idx, 2'b00}, $urandom, 4'($urandom_range(0, 15)));
      end else begin
        if (idx == 4'd10) idx = 4'd2;
        axi_read({idx, 2'b00}, model_read({idx, 2'b00}));
      end
    end
    axi_read(6'h30, 32'h0);
    axi_read(6'h3C, 32'h0);

    do_reset();
    axi_write(6'h04, 32'd10, 4'hF);
    axi_write(6'h14, 32'd4, 4'hF);
    axi_write(6'h00, 32'h08, 4'hF);
    repeat (30) @(posedge clk);
    capture(45);
    check_wave("wave4", 10, 4, 4, 3);

    cap.delete(); cap_en = 1'b1;
    prev = 1'b1; found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk); #1;
      if (pwm_out[3] && !prev) found = 1'b1;
      prev = pwm_out[3];
    end
    axi_write(6'h14, 32'd7, 4'hF);
    repeat (35) @(posedge clk);
    cap_en = 1'b0;
    check_wave("glitch", 10, 4, 7, 3);

    axi_write(6'h14, 32'd0, 4'hF);
    repeat (25) @(posedge clk);
    capture(30);
    ones = 0;
    foreach (cap[i]) ones += int'(cap[i][3]);
    check("duty0_low", 32'(ones), 32'h0);

    axi_write(6'h14, 32'd12, 4'hF);
    repeat (25) @(posedge clk);
    capture(30);
    ones = 0;
    foreach (cap[i]) ones += int'(cap[i][3]);
    check("duty12_high", 32'(ones), 32'(cap.size()));

    axi_write(6'h04, 32'd0, 4'hF);
    repeat (25) @(posedge clk);
    @(negedge clk);
    check("per0_pwm", 32'(pwm_out), 32'h0);
    axi_read(6'h28, 32'h0);

    @(posedge clk); #1;
    bus.awaddr = 6'h08; bus.wdata = 32'hCAFE0042; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("aw_only_awready", 32'(bus.awready), 0);
    end
    @(posedge clk); #1;
    bus.wvalid = 1'b1; exp_b++;
    wait_accept("aw_first");
    end_write();
    wait_b("aw_first");
    axi_read(6'h08, 32'hCAFE0042);

    bus.bready = 1'b0;
    @(posedge clk); #1;
    start_write(6'h08, 32'h11112222, 4'hF);
    wait_accept("bp1");
    end_write();
    start_write(6'h0C, 32'h33334444, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_bvalid_held", 32'(bus.bvalid), 1);
      check("bp_no_accept", 32'(bus.awready), 0);
    end
    @(posedge clk); #1;
    bus.bready = 1'b1;
    wait_accept("bp2");
    end_write();
    wait_b("bp");
    axi_read(6'h08, 32'h11112222);
    axi_read(6'h0C, 32'h33334444);

    bus.rready = 1'b0;
    @(posedge clk); #1;
    begin
      rd_exp_t x;
      int n = 0;
      x.addr = 6'h00; x.data = model_read(6'h00);
      exp_rd.push_back(x);
      bus.araddr = 6'h00; bus.arvalid = 1'b1;
      do begin @(negedge clk); n++; end while (!bus.arready && n < 100);
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.rvalid && n < 100);
      check("rst_pending_rvalid", 32'(bus.rvalid), 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rvalid",  32'(bus.rvalid), 0);
    check("async_rst_arready", 32'(bus.arready), 0);
    check("async_rst_pwm",     32'(pwm_out), 0);
    exp_rd.delete(); exp_b = 0; model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.rready = 1'b1;
    for (int r = 0; r <= 10; r++) axi_read(6'(r * 4), 32'h0);

    check("sb_rd_empty", 32'(exp_rd.size()), 32'h0);
    check("sb_b_empty", 32'(exp_b), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
